// File: rtl/shadow_trace_logger_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shadow_trace_logger_if : sampled Z80 bus, comparator flags and dump status |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface shadow_trace_logger_if;
   logic        match;
   logic        arm;
   logic [7:0]  ctrl;
   logic [15:0] A;
   logic [7:0]  D;
   logic        TXD;
   logic        busy;
   logic        triggered;

   modport master (output match, arm, ctrl, A, D, input TXD, busy, triggered);
   modport slave  (input match, arm, ctrl, A, D, output TXD, busy, triggered);
endinterface
`default_nettype wire

// File: rtl/shadow_trace_logger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shadow_trace_logger : rolling bus history frozen on mismatch, dumped 8N1   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module shadow_trace_logger #(
   parameter int DEPTH    = 16,
   parameter int POST     = 4,
   parameter int BAUD_DIV = 16
) (
   input  wire logic            CLK_n,
   input  wire logic            RESET_n,
   shadow_trace_logger_if.slave bus
);

   localparam int c_PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_VW     = c_PW + 1;
   localparam int c_NBYTES = 3 + 4 * DEPTH;
   localparam int c_BW     = $clog2(c_NBYTES);
   localparam int c_BDW    = $clog2(BAUD_DIV);
   localparam int c_CW     = (POST > 1) ? $clog2(POST) : 1;

   localparam logic [c_BDW-1:0] c_BAUD_LAST = c_BDW'(BAUD_DIV - 1);
   localparam logic [c_BW-1:0]  c_LAST_BYTE = c_BW'(c_NBYTES - 1);
   localparam logic [c_CW-1:0]  c_POST_LAST = c_CW'((POST > 0) ? POST - 1 : 0);
   localparam logic [c_VW-1:0]  c_DEPTH_V   = c_VW'(DEPTH);

   typedef enum logic [1:0] {
      ST_ARMED = 2'd0,
      ST_POST  = 2'd1,
      ST_DUMP  = 2'd2,
      ST_IDLE  = 2'd3
   } state_t;

   state_t           state_q;
   logic [c_PW-1:0]  wr_ptr_q;
   logic [c_VW-1:0]  valid_q;
   logic [c_CW-1:0]  post_cnt_q;
   logic [c_BW-1:0]  byte_idx_q;
   logic [3:0]       bit_idx_q;
   logic [c_BDW-1:0] baud_cnt_q;
   logic             lead_q;
   logic             txd_q;
   logic             busy_q;
   logic             trig_q;
   logic [31:0]      mem_q [DEPTH];

   logic [c_PW-1:0]  wr_ptr_d;
   logic [c_VW-1:0]  valid_d;
   logic             w_sample;
   logic [c_BW-1:0]  w_rec_off;
   logic [c_PW-1:0]  w_rd_addr;
   logic [1:0]       w_field;
   logic [31:0]      w_rec;
   logic [7:0]       w_byte;
   logic             w_next_bit;

   assign w_sample = (state_q == ST_ARMED) || (state_q == ST_POST);
   assign wr_ptr_d = wr_ptr_q + c_PW'(1);
   assign valid_d  = (valid_q == c_DEPTH_V) ? valid_q : valid_q + c_VW'(1);

   // Record bytes start at index 2; the frozen write pointer is the oldest slot.
   assign w_rec_off = byte_idx_q - c_BW'(2);
   assign w_rd_addr = wr_ptr_q + c_PW'(w_rec_off >> 2);
   assign w_field   = w_rec_off[1:0];
   assign w_rec     = mem_q[w_rd_addr];

   always_comb begin
      w_byte = 8'h00;
      if (byte_idx_q == '0) begin
         w_byte = 8'hA5;
      end else if (byte_idx_q == c_BW'(1)) begin
         w_byte = 8'(valid_q);
      end else if (byte_idx_q == c_LAST_BYTE) begin
         w_byte = 8'h5A;
      end else begin
         case (w_field)
            2'd0:    w_byte = w_rec[31:24];
            2'd1:    w_byte = w_rec[23:16];
            2'd2:    w_byte = w_rec[15:8];
            default: w_byte = w_rec[7:0];
         endcase
      end
   end

   // Bit slot n (1..8) carries data bit n-1; slot 9 is the stop bit.
   assign w_next_bit = (bit_idx_q == 4'd8) ? 1'b1 : w_byte[bit_idx_q[2:0]];

   always_ff @(posedge CLK_n) begin
      if (w_sample) begin
         mem_q[wr_ptr_q] <= {bus.ctrl, bus.A, bus.D};
      end
   end

   always_ff @(posedge CLK_n or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q    <= ST_ARMED;
         wr_ptr_q   <= '0;
         valid_q    <= '0;
         post_cnt_q <= '0;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         baud_cnt_q <= '0;
         lead_q     <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         trig_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               wr_ptr_q <= wr_ptr_d;
               valid_q  <= valid_d;
               if (!bus.match) begin
                  trig_q     <= 1'b1;
                  post_cnt_q <= '0;
                  if (POST == 0) begin
                     state_q <= ST_DUMP;
                     busy_q  <= 1'b1;
                     lead_q  <= 1'b1;
                  end else begin
                     state_q <= ST_POST;
                  end
               end
            end
            ST_POST: begin
               wr_ptr_q   <= wr_ptr_d;
               valid_q    <= valid_d;
               post_cnt_q <= post_cnt_q + c_CW'(1);
               if (post_cnt_q == c_POST_LAST) begin
                  state_q <= ST_DUMP;
                  busy_q  <= 1'b1;
                  lead_q  <= 1'b1;
               end
            end
            ST_DUMP: begin
               // One quiet cycle after entry, then back-to-back frames.
               if (lead_q) begin
                  lead_q     <= 1'b0;
                  txd_q      <= 1'b0;
                  baud_cnt_q <= '0;
               end else if (baud_cnt_q == c_BAUD_LAST) begin
                  baud_cnt_q <= '0;
                  if (bit_idx_q == 4'd9) begin
                     bit_idx_q <= '0;
                     if (byte_idx_q == c_LAST_BYTE) begin
                        state_q    <= ST_IDLE;
                        byte_idx_q <= '0;
                        txd_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        trig_q     <= 1'b0;
                     end else begin
                        byte_idx_q <= byte_idx_q + c_BW'(1);
                        txd_q      <= 1'b0;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 4'd1;
                     txd_q     <= w_next_bit;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + c_BDW'(1);
               end
            end
            ST_IDLE: begin
               if (bus.arm) begin
                  state_q <= ST_ARMED;
                  valid_q <= '0;
               end
            end
            default: state_q <= ST_ARMED;
         endcase
      end
   end

   assign bus.TXD       = txd_q;
   assign bus.busy      = busy_q;
   assign bus.triggered = trig_q;

endmodule
`default_nettype wire

// File: doc/shadow_trace_logger.md
# shadow_trace_logger

Downstream of the shadow-tracer comparator. It keeps a rolling history of the sampled Z80 bus (control, address, data) and freezes that history when the comparator's `match` flag drops. After a programmable number of post-trigger samples, it streams the captured window out on `TXD` as 8N1 serial frames. This lets a host see the bus cycles before and after the first divergence between the T80 shadow core and the real CPU.

## Interface
Parameters:
- `DEPTH`, 16: history entries; power of two, 2..128.
- `POST`, 4: samples recorded after the trigger sample; 0..DEPTH-1.
- `BAUD_DIV`, 16: clock cycles per serial bit; ≥2.

Ports:
- `CLK_n`  in  1: the only clock; all logic on its rising edge.
- `RESET_n`  in  1: asynchronous, active-low reset.
- `match`  in  1: comparator result; 0 = mismatch.
- `arm`  in  1: re-arm request; honoured only in IDLE.
- `ctrl`  in  8: {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, HALT_n, BUSAK_n}, bit 7 first.
- `A`  in  16: external address bus.
- `D`  in  8: external data bus.
- `TXD`  out  1: serial output; idle high.
- `busy`  out  1: 1 while in DUMP.
- `triggered`  out  1: 1 from the trigger edge until return to IDLE.

## Operation
- States: ARMED, POST, DUMP, IDLE. Reset enters ARMED.
- Reset values: `TXD`=1, `busy`=0, `triggered`=0, `wr_ptr`=0, `valid`=0, POST counter=0. History RAM contents are don't-care.
- **ARMED**
  - Each edge writes {ctrl, A, D} at `wr_ptr`, then `wr_ptr`++ mod DEPTH.
  - `valid` = saturating count of writes since arming, max DEPTH.
  - If `match`=0 at an edge, that sample is written as the trigger sample and `triggered` is set.
  - Next state is POST, or DUMP if POST=0.
- **POST**
  - Each edge writes a sample exactly as in ARMED.
  - After the POST-th write, next state is DUMP. `match` is ignored.
- **DUMP**
  - No sampling.
  - Sends 3+4·DEPTH bytes, in order:
    - 0xA5
    - `valid`
    - DEPTH records, oldest first, starting at `wr_ptr` (the value frozen at DUMP entry). Each record is ctrl, A[15:8], A[7:0], D.
    - 0x5A
  - The trigger record sits at record index DEPTH-1-POST.
  - Records not written since arming carry stale data; the host uses `valid`.
- **IDLE**
  - Entered when the stop bit of 0x5A ends; `triggered` clears.
  - `arm`=1 at an edge moves to ARMED and clears `valid`; `wr_ptr` keeps its value.
- `arm` is ignored in ARMED, POST and DUMP. `match` is ignored outside ARMED.
- Serial format: 8N1, LSB first. The start bit is low and the stop bit is high. The next byte's start bit follows the previous stop bit with no gap.

## Timing
- The trigger edge (`match`=0 sampled in ARMED) is edge T:
  - `triggered`=1 after T.
  - DUMP is entered at edge T+POST.
  - `busy`=1 after T+POST.
  - `TXD` drops for the first start bit after edge T+POST+1.
- Every serial bit lasts exactly BAUD_DIV cycles. One byte takes 10·BAUD_DIV cycles.
- `busy` stays high for exactly 1 + (3+4·DEPTH)·10·BAUD_DIV cycles. It and `triggered` fall at the same edge that enters IDLE.
- Asserting `RESET_n`=0 mid-operation immediately forces the reset values: `TXD`=1 and the partial frame is abandoned. Deasserting it resumes in ARMED.
- Sampling latency: the value on A/D/ctrl at edge k is stored at edge k. No input registering; upstream already aligns the bus to `CLK_n`.

## Test plan
- **Reset:** hold `RESET_n`=0 with toggling inputs → `TXD`=1, `busy`=0, `triggered`=0. Release with `match`=1 → no TXD activity for 1000 cycles.
- **Nominal:** DEPTH=16, POST=4, BAUD_DIV=4; A = sample index; drop `match` at sample 20.
  - TXD carries 67 bytes: A5, 10, records with A=9..24, trigger record A=20 at index 11, then 5A.
  - `busy` is high for 2681 cycles.
- **Early trigger:** `match`=0 on the 3rd sample after reset (same parameters) → `valid` byte = 07.
- **POST=0:** `busy` rises after the trigger edge; the last record is the trigger sample.
- **Arm and match handling:**
  - `arm` pulses during DUMP → ignored.
  - In IDLE, `match`=0 with no `arm` → no capture.
  - `arm` then mismatch → a second dump with `valid` counted from the re-arm.
- **Reset mid-dump:** assert `RESET_n` during the 5th byte → `TXD`=1 immediately and `busy`=0. The next mismatch produces a complete, well-formed dump.
